// File: rtl/k423_pcu_if.sv
// Pipeline-control bundle between the core pipeline and the k423 pipeline
// control unit: ID/EX/WB hazard sources in, stall/clear/redirect controls
// and status counters out.
`ifndef K423_PCU_DEFS
`define K423_PCU_DEFS
`define INST_RSDIDX_W 5
`define CORE_ADDR_W   32
`endif

interface k423_pcu_if;
    // ID-stage source operands
    logic                       id_vld_i;
    logic                       id_rs1_vld_i;
    logic [`INST_RSDIDX_W-1:0]  id_rs1_idx_i;
    logic                       id_rs2_vld_i;
    logic [`INST_RSDIDX_W-1:0]  id_rs2_idx_i;
    // EX-stage destination
    logic                       ex_vld_i;
    logic                       ex_rd_vld_i;
    logic [`INST_RSDIDX_W-1:0]  ex_rd_idx_i;
    logic                       ex_rd_load_i;
    // WB load / data-memory response / redirect
    logic                       wb_vld_i;
    logic                       wb_rd_load_i;
    logic                       dmem_rsp_vld_i;
    logic                       wb_redirect_i;
    logic [`CORE_ADDR_W-1:0]    wb_redirect_pc_i;
    // Pipeline controls
    logic                       pcu_stall_if_o;
    logic                       pcu_stall_if_id_o;
    logic                       pcu_stall_id_ex_o;
    logic                       pcu_stall_ex_wb_o;
    logic                       pcu_clear_if_id_o;
    logic                       pcu_clear_id_ex_o;
    logic                       pcu_clear_ex_wb_o;
    logic                       pcu_redirect_vld_o;
    logic [`CORE_ADDR_W-1:0]    pcu_redirect_pc_o;
    // Status
    logic                       pcu_dwait_tmo_o;
    logic [31:0]                pcu_stall_cnt_o;
    logic [31:0]                pcu_flush_cnt_o;

    // Control-unit side
    modport slave (
        input  id_vld_i, id_rs1_vld_i, id_rs1_idx_i, id_rs2_vld_i, id_rs2_idx_i,
        input  ex_vld_i, ex_rd_vld_i, ex_rd_idx_i, ex_rd_load_i,
        input  wb_vld_i, wb_rd_load_i, dmem_rsp_vld_i, wb_redirect_i, wb_redirect_pc_i,
        output pcu_stall_if_o, pcu_stall_if_id_o, pcu_stall_id_ex_o, pcu_stall_ex_wb_o,
        output pcu_clear_if_id_o, pcu_clear_id_ex_o, pcu_clear_ex_wb_o,
        output pcu_redirect_vld_o, pcu_redirect_pc_o,
        output pcu_dwait_tmo_o, pcu_stall_cnt_o, pcu_flush_cnt_o
    );

    // Pipeline side
    modport master (
        output id_vld_i, id_rs1_vld_i, id_rs1_idx_i, id_rs2_vld_i, id_rs2_idx_i,
        output ex_vld_i, ex_rd_vld_i, ex_rd_idx_i, ex_rd_load_i,
        output wb_vld_i, wb_rd_load_i, dmem_rsp_vld_i, wb_redirect_i, wb_redirect_pc_i,
        input  pcu_stall_if_o, pcu_stall_if_id_o, pcu_stall_id_ex_o, pcu_stall_ex_wb_o,
        input  pcu_clear_if_id_o, pcu_clear_id_ex_o, pcu_clear_ex_wb_o,
        input  pcu_redirect_vld_o, pcu_redirect_pc_o,
        input  pcu_dwait_tmo_o, pcu_stall_cnt_o, pcu_flush_cnt_o
    );
endinterface

// File: rtl/k423_pcu.sv
// k423 pipeline control unit: resolves WB redirects, WB load data waits and
// EX->ID load-use hazards into zero-latency stall/clear/redirect controls for
// a four-stage IF/ID/EX/WB pipeline, plus a sticky data-wait timeout flag and
// saturating stall/flush performance counters.
`ifndef K423_PCU_DEFS
`define K423_PCU_DEFS
`define INST_RSDIDX_W 5
`define CORE_ADDR_W   32
`endif

module k423_pcu #(
    parameter int unsigned DWAIT_TMO = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    k423_pcu_if.slave   pcu
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] TMO_VAL = 8'(DWAIT_TMO);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  wait_cnt_q;
    logic        tmo_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    logic        redirect;
    logic        dwait;
    logic        ldu;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        tmo_hit;
    logic        any_stall;

    logic        stall_if;
    logic        stall_if_id;
    logic        stall_id_ex;
    logic        stall_ex_wb;
    logic        clear_if_id;
    logic        clear_id_ex;
    logic        clear_ex_wb;
    logic        redir_vld;
    logic [`CORE_ADDR_W-1:0] redir_pc;

    // Event detection from the current pipeline contents.
    assign redirect = pcu.wb_vld_i & pcu.wb_redirect_i;
    assign dwait    = pcu.wb_vld_i & pcu.wb_rd_load_i & ~pcu.dmem_rsp_vld_i;
    assign rs1_hit  = pcu.id_rs1_vld_i & (pcu.id_rs1_idx_i == pcu.ex_rd_idx_i);
    assign rs2_hit  = pcu.id_rs2_vld_i & (pcu.id_rs2_idx_i == pcu.ex_rd_idx_i);
    // x0 is never a real dependency, so a load targeting it cannot cause a hazard.
    assign ldu      = pcu.id_vld_i & pcu.ex_vld_i & pcu.ex_rd_load_i & pcu.ex_rd_vld_i
                    & (pcu.ex_rd_idx_i != '0) & (rs1_hit | rs2_hit);

    // Prioritised control decode (redirect > data wait > load-use) and next state.
    always_comb begin
        state_d     = state_q;
        stall_if    = 1'b0;
        stall_if_id = 1'b0;
        stall_id_ex = 1'b0;
        stall_ex_wb = 1'b0;
        clear_if_id = 1'b0;
        clear_id_ex = 1'b0;
        clear_ex_wb = 1'b0;
        redir_vld   = 1'b0;
        redir_pc    = '0;
        if (rst_i) begin
            state_d = ST_RUN;
        end else if (redirect) begin
            clear_if_id = 1'b1;
            clear_id_ex = 1'b1;
            clear_ex_wb = 1'b1;
            redir_vld   = 1'b1;
            redir_pc    = pcu.wb_redirect_pc_i;
            state_d     = ST_FLUSH;
        end else if (state_q == ST_FLUSH) begin
            // The fetch issued in the redirect cycle came from the old path.
            clear_if_id = 1'b1;
            state_d     = ST_RUN;
        end else if (dwait) begin
            stall_if    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
            stall_ex_wb = 1'b1;
            state_d     = ST_DWAIT;
        end else if (state_q == ST_DWAIT) begin
            // Response cycle: the load retires and the pipeline moves on.
            state_d = ST_RUN;
        end else if (ldu) begin
            // Hold IF and ID, inject one bubble into EX.
            stall_if    = 1'b1;
            stall_if_id = 1'b1;
            clear_id_ex = 1'b1;
        end
    end

    assign any_stall = stall_if | stall_if_id | stall_id_ex | stall_ex_wb;
    // Timeout is visible in the same cycle the wait counter reaches the threshold.
    assign tmo_hit   = ~rst_i & (state_q == ST_DWAIT) & (wait_cnt_q == TMO_VAL);

    // State, wait counter, sticky timeout and saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            tmo_q       <= 1'b0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if ((state_q != ST_DWAIT) && (state_d == ST_DWAIT)) begin
                wait_cnt_q <= 8'd0;
            end else if ((state_q == ST_DWAIT) && (wait_cnt_q != 8'hFF)) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            if (tmo_hit) begin
                tmo_q <= 1'b1;
            end
            if (any_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redir_vld && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign pcu.pcu_stall_if_o     = stall_if;
    assign pcu.pcu_stall_if_id_o  = stall_if_id;
    assign pcu.pcu_stall_id_ex_o  = stall_id_ex;
    assign pcu.pcu_stall_ex_wb_o  = stall_ex_wb;
    assign pcu.pcu_clear_if_id_o  = clear_if_id;
    assign pcu.pcu_clear_id_ex_o  = clear_id_ex;
    assign pcu.pcu_clear_ex_wb_o  = clear_ex_wb;
    assign pcu.pcu_redirect_vld_o = redir_vld;
    assign pcu.pcu_redirect_pc_o  = redir_pc;
    assign pcu.pcu_dwait_tmo_o    = tmo_q | tmo_hit;
    assign pcu.pcu_stall_cnt_o    = stall_cnt_q;
    assign pcu.pcu_flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_k423_pcu.sv
// Testbench for k423_pcu: table of per-cycle vectors applied through a
// scoreboard queue, followed by hand-written multi-cycle sequences that also
// check the performance counters and the sticky data-wait timeout.
module tb_k423_pcu;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    k423_pcu_if bus();

    k423_pcu #(.DWAIT_TMO(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .pcu   (bus.slave)
    );

    // Expected control vector bit order:
    // {stall_if, stall_if_id, stall_id_ex, stall_ex_wb, clr_if_id, clr_id_ex, clr_ex_wb, redirect_vld}
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_LDU  = 8'b1100_0100;
    localparam logic [7:0] E_STL  = 8'b1111_0000;
    localparam logic [7:0] E_RDR  = 8'b0000_1111;
    localparam logic [7:0] E_FL1  = 8'b0000_1000;

    typedef struct {
        string       name;
        logic        rst;
        logic        idv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        exv;
        logic [4:0]  rd;
        logic        ld;
        logic        wbv;
        logic        wbld;
        logic        rsp;
        logic        rdr;
        logic [31:0] pc;
        logic [7:0]  exp;
        logic        tmo;
    } vec_t;

    typedef struct {
        string       name;
        logic [7:0]  ctrl;
        logic [31:0] pc;
        logic        tmo;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(string n, logic r, logic idv, logic [4:0] rs1, logic [4:0] rs2,
                                logic exv, logic [4:0] rd, logic ld, logic wbv, logic wbld,
                                logic rsp, logic rdr, logic [31:0] pc, logic [7:0] e, logic t);
        vec_t v;
        v.name = n; v.rst = r; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2;
        v.exv = exv; v.rd = rd; v.ld = ld; v.wbv = wbv; v.wbld = wbld;
        v.rsp = rsp; v.rdr = rdr; v.pc = pc; v.exp = e; v.tmo = t;
        return v;
    endfunction

    function automatic vec_t idl(string n, logic [7:0] e, logic t);
        return mk(n, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e, t);
    endfunction

    function automatic vec_t rstv(string n, logic t);
        return mk(n, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, E_NONE, t);
    endfunction

    function automatic vec_t hz(string n, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic ld, logic [7:0] e);
        return mk(n, 1'b0, 1'b1, rs1, rs2, 1'b1, rd, ld, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e, 1'b0);
    endfunction

    function automatic vec_t dw(string n, logic [7:0] e, logic t);
        return mk(n, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, e, t);
    endfunction

    function automatic vec_t rspv(string n, logic [7:0] e, logic t);
        return mk(n, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, e, t);
    endfunction

    function automatic vec_t rdv(string n, logic [31:0] pc, logic [7:0] e);
        return mk(n, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pc, e, 1'b0);
    endfunction

    // Drive one cycle of stimulus after the rising edge, sample at the falling edge.
    task automatic step(input vec_t v);
        exp_t       x;
        logic [7:0] act;
        @(posedge clk);
        #1;
        rst                  = v.rst;
        bus.id_vld_i         = v.idv;
        bus.id_rs1_vld_i     = v.idv;
        bus.id_rs1_idx_i     = v.rs1;
        bus.id_rs2_vld_i     = v.idv;
        bus.id_rs2_idx_i     = v.rs2;
        bus.ex_vld_i         = v.exv;
        bus.ex_rd_vld_i      = v.exv;
        bus.ex_rd_idx_i      = v.rd;
        bus.ex_rd_load_i     = v.ld;
        bus.wb_vld_i         = v.wbv;
        bus.wb_rd_load_i     = v.wbld;
        bus.dmem_rsp_vld_i   = v.rsp;
        bus.wb_redirect_i    = v.rdr;
        bus.wb_redirect_pc_i = v.pc;
        x.name = v.name;
        x.ctrl = v.exp;
        x.pc   = v.exp[0] ? v.pc : 32'h0;
        x.tmo  = v.tmo;
        sb.push_back(x);
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got nothing to compare, required one entry", v.name);
        end else begin
            x   = sb.pop_front();
            act = {bus.pcu_stall_if_o, bus.pcu_stall_if_id_o, bus.pcu_stall_id_ex_o,
                   bus.pcu_stall_ex_wb_o, bus.pcu_clear_if_id_o, bus.pcu_clear_id_ex_o,
                   bus.pcu_clear_ex_wb_o, bus.pcu_redirect_vld_o};
            if (act === x.ctrl && bus.pcu_redirect_pc_o === x.pc && bus.pcu_dwait_tmo_o === x.tmo)
                passed++;
            else
                $display("FAIL %s: got ctrl=%b pc=%h tmo=%b, required ctrl=%b pc=%h tmo=%b",
                         x.name, act, bus.pcu_redirect_pc_o, bus.pcu_dwait_tmo_o,
                         x.ctrl, x.pc, x.tmo);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", n, act, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.id_vld_i = 1'b0; bus.id_rs1_vld_i = 1'b0; bus.id_rs1_idx_i = 5'd0;
        bus.id_rs2_vld_i = 1'b0; bus.id_rs2_idx_i = 5'd0;
        bus.ex_vld_i = 1'b0; bus.ex_rd_vld_i = 1'b0; bus.ex_rd_idx_i = 5'd0; bus.ex_rd_load_i = 1'b0;
        bus.wb_vld_i = 1'b0; bus.wb_rd_load_i = 1'b0; bus.dmem_rsp_vld_i = 1'b0;
        bus.wb_redirect_i = 1'b0; bus.wb_redirect_pc_i = 32'h0;
        repeat (2) @(posedge clk);

        // Per-cycle vector table; state carries from one row to the next.
        tbl.push_back(mk("rst_blocks_redirect", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         1'b1, 1'b0, 1'b0, 1'b1, 32'h123, E_NONE, 1'b0));
        tbl.push_back(mk("rst_blocks_dwait", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         1'b1, 1'b1, 1'b0, 1'b0, 32'h0, E_NONE, 1'b0));
        tbl.push_back(idl("idle", E_NONE, 1'b0));
        tbl.push_back(hz("ldu_rs2", 5'd7, 5'd5, 5'd5, 1'b1, E_LDU));
        tbl.push_back(mk("ldu_bubble", 1'b0, 1'b1, 5'd7, 5'd5, 1'b0, 5'd5, 1'b1,
                         1'b0, 1'b0, 1'b0, 1'b0, 32'h0, E_NONE, 1'b0));
        tbl.push_back(hz("ldu_rd0", 5'd0, 5'd0, 5'd0, 1'b1, E_NONE));
        tbl.push_back(hz("ldu_rs1", 5'd9, 5'd3, 5'd9, 1'b1, E_LDU));
        tbl.push_back(hz("ex_not_load", 5'd9, 5'd3, 5'd9, 1'b0, E_NONE));
        tbl.push_back(mk("id_invalid", 1'b0, 1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1,
                         1'b0, 1'b0, 1'b0, 1'b0, 32'h0, E_NONE, 1'b0));
        tbl.push_back(mk("redir_no_wbv", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, E_NONE, 1'b0));
        tbl.push_back(dw("dwait_1", E_STL, 1'b0));
        tbl.push_back(dw("dwait_2", E_STL, 1'b0));
        tbl.push_back(mk("dwait_over_ldu", 1'b0, 1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1,
                         1'b1, 1'b1, 1'b0, 1'b0, 32'h0, E_STL, 1'b0));
        tbl.push_back(rspv("dwait_rsp", E_NONE, 1'b0));
        tbl.push_back(idl("after_rsp", E_NONE, 1'b0));
        tbl.push_back(mk("redir_over_ldu", 1'b0, 1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1,
                         1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0040, E_RDR, 1'b0));
        tbl.push_back(mk("flush_ignores_events", 1'b0, 1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1,
                         1'b1, 1'b1, 1'b0, 1'b0, 32'h0, E_FL1, 1'b0));
        tbl.push_back(idl("after_flush", E_NONE, 1'b0));
        tbl.push_back(dw("dwait_3", E_STL, 1'b0));
        tbl.push_back(mk("redir_in_dwait", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, E_RDR, 1'b0));
        tbl.push_back(rdv("redir_in_flush", 32'h0000_0200, E_RDR));
        tbl.push_back(idl("flush_2", E_FL1, 1'b0));
        tbl.push_back(idl("idle_end", E_NONE, 1'b0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Single load-use bubble with stall count.
        step(rstv("s26_rst", 1'b0));
        step(hz("s26_ldu", 5'd7, 5'd5, 5'd5, 1'b1, E_LDU));
        step(idl("s26_next", E_NONE, 1'b0));
        chk32("s26_stall_cnt", bus.pcu_stall_cnt_o, 32'd1);

        // Load to x0 never stalls.
        step(rstv("s27_rst", 1'b0));
        step(hz("s27_ldu_rd0", 5'd7, 5'd0, 5'd0, 1'b1, E_NONE));
        step(idl("s27_next", E_NONE, 1'b0));
        chk32("s27_stall_cnt", bus.pcu_stall_cnt_o, 32'd0);

        // Redirect followed by one fetch-drop cycle.
        step(rstv("s28_rst", 1'b0));
        step(rdv("s28_redirect", 32'h8000_0040, E_RDR));
        step(idl("s28_flush", E_FL1, 1'b0));
        step(idl("s28_run", E_NONE, 1'b0));
        chk32("s28_flush_cnt", bus.pcu_flush_cnt_o, 32'd1);
        chk32("s28_stall_cnt", bus.pcu_stall_cnt_o, 32'd0);

        // Three-cycle data wait.
        step(rstv("s29_rst", 1'b0));
        for (int k = 1; k <= 3; k++) step(dw($sformatf("s29_dwait_%0d", k), E_STL, 1'b0));
        step(rspv("s29_rsp", E_NONE, 1'b0));
        step(idl("s29_run", E_NONE, 1'b0));
        chk32("s29_stall_cnt", bus.pcu_stall_cnt_o, 32'd3);

        // Timeout with threshold 4: first cycle enters DWAIT, the flag shows
        // on the fifth cycle spent in DWAIT (cycle 6 overall) and stays set.
        step(rstv("s30_rst", 1'b0));
        for (int k = 1; k <= 10; k++)
            step(dw($sformatf("s30_dwait_%0d", k), E_STL, (k >= 6)));
        step(rspv("s30_rsp", E_NONE, 1'b1));
        step(idl("s30_sticky", E_NONE, 1'b1));
        chk32("s30_stall_cnt", bus.pcu_stall_cnt_o, 32'd10);
        step(rstv("s30_rst_pulse", 1'b1));
        step(idl("s30_after_rst", E_NONE, 1'b0));
        chk32("s30_stall_cnt_rst", bus.pcu_stall_cnt_o, 32'd0);
        chk32("s30_flush_cnt_rst", bus.pcu_flush_cnt_o, 32'd0);

        // Redirect beats load-use in the same cycle.
        step(rstv("s31_rst", 1'b0));
        step(mk("s31_redir_ldu", 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4000, E_RDR, 1'b0));
        step(idl("s31_flush", E_FL1, 1'b0));
        step(idl("s31_idle", E_NONE, 1'b0));
        chk32("s31_stall_cnt", bus.pcu_stall_cnt_o, 32'd0);

        // Reset in the middle of DWAIT: RUN on the next cycle, so a load-use
        // hazard is honoured immediately.
        step(rstv("s31b_rst", 1'b0));
        step(dw("s31b_dwait_1", E_STL, 1'b0));
        step(dw("s31b_dwait_2", E_STL, 1'b0));
        step(mk("s31b_rst_in_dwait", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b0, 32'h0, E_NONE, 1'b0));
        step(hz("s31b_run_ldu", 5'd4, 5'd2, 5'd4, 1'b1, E_LDU));
        step(idl("s31b_idle", E_NONE, 1'b0));
        chk32("s31b_stall_cnt", bus.pcu_stall_cnt_o, 32'd1);

        // Reset in the middle of FLUSH: no fetch-drop afterwards.
        step(rdv("s31c_redirect", 32'h0000_0080, E_RDR));
        step(rstv("s31c_rst_in_flush", 1'b0));
        step(idl("s31c_idle", E_NONE, 1'b0));
        chk32("s31c_flush_cnt", bus.pcu_flush_cnt_o, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
